// File: rtl/display_pkg.sv
// Shared display types: number width, display limit and scheduler state.
// Also used by the 7-segment display driver.
package display_pkg;

  localparam int NUM_W       = 14;
  localparam int MAX_DISPLAY = 9999;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  function automatic logic [NUM_W-1:0] clamp_num(
    input logic [NUM_W-1:0] v
  );
    return (v > NUM_W'(MAX_DISPLAY)) ? NUM_W'(MAX_DISPLAY) : v;
  endfunction

endpackage

// File: rtl/display_scheduler_rr_picker.sv
// Combinational round-robin picker: first set req at or after start,
// wrapping, optionally skipping one masked index.
module rr_picker #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mask_en,
  input  logic [W-1:0] mask,
  output logic         found,
  output logic [W-1:0] idx
);

  // Walk from the far end so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(start) + k) % N;
      if (req[j] && !(mask_en && j == int'(mask))) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of one 4-digit display between requesters,
// with a minimum dwell before a contested owner is pre-empted.
module display_scheduler
  import display_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int DWELL_CYCLES = 100_000_000,
  localparam int W            = $clog2(N_REQ),
  localparam int DW           = (DWELL_CYCLES > 1) ?
                                $clog2(DWELL_CYCLES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [NUM_W*N_REQ-1:0] number_in,
  output logic [N_REQ-1:0]       grant,
  output logic [W-1:0]           owner,
  output logic [NUM_W-1:0]       number_out,
  output logic                   blank
);

  localparam logic [DW-1:0] DMAX = DW'(DWELL_CYCLES - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_e        state_q, state_n;
  logic [W-1:0]  owner_n;
  logic [DW-1:0] dwell_q, dwell_n;
  logic [W-1:0]  rr_q, rr_n;

  logic          found;
  logic [W-1:0]  pick;
  logic [W-1:0]  pick_start;
  logic [NUM_W-1:0] sel_num;

  function automatic logic [W-1:0] inc(input logic [W-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : W'(32'(i) + 1);
  endfunction

  assign pick_start = (state_q == OWN) ? inc(owner) : rr_q;
  assign sel_num    = number_in[NUM_W*owner +: NUM_W];

  rr_picker #(.N(N_REQ)) u_pick (
    .req     (req),
    .start   (pick_start),
    .mask_en (state_q == OWN),
    .mask    (owner),
    .found   (found),
    .idx     (pick)
  );

  always_comb begin
    state_n = state_q;
    owner_n = owner;
    dwell_n = dwell_q;
    rr_n    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_n = OWN;
          owner_n = pick;
          dwell_n = '0;
          rr_n    = inc(pick);
        end
      end
      OWN: begin
        // Release wins over dwell expiry when both happen together.
        if (!req[owner]) begin
          if (found) begin
            owner_n = pick;
            dwell_n = '0;
            rr_n    = inc(pick);
          end else begin
            state_n = IDLE;
            owner_n = '0;
            dwell_n = '0;
          end
        end else if (dwell_q == DMAX && found) begin
          owner_n = pick;
          dwell_n = '0;
          rr_n    = inc(pick);
        end else if (dwell_q != DMAX) begin
          dwell_n = dwell_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner      <= '0;
      dwell_q    <= '0;
      rr_q       <= '0;
      grant      <= '0;
      blank      <= 1'b1;
      number_out <= '0;
    end else begin
      state_q    <= state_n;
      owner      <= owner_n;
      dwell_q    <= dwell_n;
      rr_q       <= rr_n;
      grant      <= (state_n == OWN) ? (ONE << owner_n) : '0;
      blank      <= (state_n == IDLE);
      number_out <= (state_q == OWN && state_n == OWN) ?
                    clamp_num(sel_num) : '0;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler (N_REQ=4, DWELL_CYCLES=8).
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [13:0] nums [4];
  logic [55:0] number_in;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [13:0] number_out;
  logic        blank;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  g;
    logic [1:0]  o;
    logic        b;
    logic [13:0] n;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  assign number_in = {nums[3], nums[2], nums[1], nums[0]};

  always #5 clk = ~clk;

  display_scheduler #(.N_REQ(4), .DWELL_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .number_in  (number_in),
    .grant      (grant),
    .owner      (owner),
    .number_out (number_out),
    .blank      (blank)
  );

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL onehot0: grant=%b at %0t", grant, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(logic [3:0] g, logic [1:0] o,
                              logic b, logic [13:0] n);
    exp_t x;
    x.g = g; x.o = o; x.b = b; x.n = n;
    return x;
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    req   = '0;
    for (int i = 0; i < 4; i++) nums[i] = '0;
    repeat (3) tick();
    checks++;
    if (grant !== 4'b0 || owner !== 2'd0 || blank !== 1'b1 ||
        number_out !== 14'd0) begin
      errors++;
      $display("FAIL reset: g=%b o=%0d b=%b n=%0d want 0000/0/1/0",
               grant, owner, blank, number_out);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0 || blank !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: g=%b b=%b want 0000/1", grant, blank);
    end
  endtask

  task automatic test_single;
    nums[0] = 14'd1234;
    for (int c = 0; c <= 50; c++) begin
      req = (c < 50) ? 4'b0001 : 4'b0000;
      if (c < 50)
        sbq.push_back(mk(4'b0001, 2'd0, 1'b0, (c == 0) ? 14'd0 : 14'd1234));
      else
        sbq.push_back(mk(4'b0000, 2'd0, 1'b1, 14'd0));
      tick();
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || owner !== e.o || blank !== e.b ||
          number_out !== e.n) begin
        errors++;
        $display("FAIL single c=%0d: g=%b o=%0d b=%b n=%0d want %b/%0d/%b/%0d",
                 c, grant, owner, blank, number_out, e.g, e.o, e.b, e.n);
      end
    end
  endtask

  task automatic test_preempt;
    int k;
    nums[0] = 14'd1234;
    nums[2] = 14'd42;
    for (int c = 0; c <= 20; c++) begin
      k   = c + 1;
      req = (c == 20) ? 4'b0000 : (c < 4) ? 4'b0001 : 4'b0101;
      if (c == 20)
        sbq.push_back(mk(4'b0000, 2'd0, 1'b1, 14'd0));
      else if (k <= 8)
        sbq.push_back(mk(4'b0001, 2'd0, 1'b0, (k == 1) ? 14'd0 : 14'd1234));
      else if (k <= 16)
        sbq.push_back(mk(4'b0100, 2'd2, 1'b0, (k == 9) ? 14'd1234 : 14'd42));
      else
        sbq.push_back(mk(4'b0001, 2'd0, 1'b0, (k == 17) ? 14'd42 : 14'd1234));
      tick();
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || owner !== e.o || blank !== e.b ||
          number_out !== e.n) begin
        errors++;
        $display("FAIL preempt k=%0d: g=%b o=%0d b=%b n=%0d want %b/%0d/%b/%0d",
                 k, grant, owner, blank, number_out, e.g, e.o, e.b, e.n);
      end
    end
  endtask

  task automatic test_release;
    logic [3:0] rq [6];
    exp_t       ex [6];
    nums[1] = 14'd77;
    nums[3] = 14'd300;
    rq = '{4'b0010, 4'b1011, 4'b1011, 4'b1001, 4'b1001, 4'b0000};
    ex[0] = mk(4'b0010, 2'd1, 1'b0, 14'd0);
    ex[1] = mk(4'b0010, 2'd1, 1'b0, 14'd77);
    ex[2] = mk(4'b0010, 2'd1, 1'b0, 14'd77);
    ex[3] = mk(4'b1000, 2'd3, 1'b0, 14'd77);
    ex[4] = mk(4'b1000, 2'd3, 1'b0, 14'd300);
    ex[5] = mk(4'b0000, 2'd0, 1'b1, 14'd0);
    for (int c = 0; c < 6; c++) begin
      req = rq[c];
      sbq.push_back(ex[c]);
      tick();
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || owner !== e.o || blank !== e.b ||
          number_out !== e.n) begin
        errors++;
        $display("FAIL release c=%0d: g=%b o=%0d b=%b n=%0d want %b/%0d/%b/%0d",
                 c, grant, owner, blank, number_out, e.g, e.o, e.b, e.n);
      end
    end
  endtask

  task automatic test_clamp;
    logic [13:0] nt [6];
    logic [13:0] en [6];
    nt = '{14'd16383, 14'd16383, 14'd10000, 14'd9999, 14'd5, 14'd5};
    en = '{14'd0, 14'd9999, 14'd9999, 14'd9999, 14'd5, 14'd0};
    for (int c = 0; c < 6; c++) begin
      req     = (c < 5) ? 4'b0001 : 4'b0000;
      nums[0] = nt[c];
      sbq.push_back(mk((c < 5) ? 4'b0001 : 4'b0000, 2'd0,
                       (c == 5), en[c]));
      tick();
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || blank !== e.b || number_out !== e.n) begin
        errors++;
        $display("FAIL clamp c=%0d: g=%b b=%b n=%0d want %b/%b/%0d",
                 c, grant, blank, number_out, e.g, e.b, e.n);
      end
    end
  endtask

  task automatic test_async_reset;
    nums[2] = 14'd4321;
    req = 4'b0100;
    repeat (2) tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2 || number_out !== 14'd4321) begin
      errors++;
      $display("FAIL pre_reset: g=%b o=%0d n=%0d want 0100/2/4321",
               grant, owner, number_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0 || owner !== 2'd0 || blank !== 1'b1 ||
        number_out !== 14'd0) begin
      errors++;
      $display("FAIL async_reset: g=%b o=%0d b=%b n=%0d want 0000/0/1/0",
               grant, owner, blank, number_out);
    end
    req = '0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0 || blank !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: g=%b b=%b want 0000/1", grant, blank);
    end
  endtask

  task automatic test_fairness;
    int o;
    int p;
    for (int i = 0; i < 4; i++) nums[i] = 14'(10 + i);
    for (int c = 0; c <= 64; c++) begin
      req = (c < 64) ? 4'b1111 : 4'b0000;
      o   = (c / 8) % 4;
      p   = ((c - 1) / 8) % 4;
      if (c == 64)
        sbq.push_back(mk(4'b0000, 2'd0, 1'b1, 14'd0));
      else
        sbq.push_back(mk(4'b0001 << o, 2'(o), 1'b0,
                         (c == 0) ? 14'd0 : 14'(10 + p)));
      tick();
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || owner !== e.o || blank !== e.b ||
          number_out !== e.n) begin
        errors++;
        $display("FAIL fair c=%0d: g=%b o=%0d b=%b n=%0d want %b/%0d/%b/%0d",
                 c, grant, owner, blank, number_out, e.g, e.o, e.b, e.n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_release();
    test_clamp();
    test_async_reset();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
